// File: rtl/wb_cmd_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_cmd_initiator_pkg
// Purpose : Shared types and constants for the Wishbone command initiator.
//           Defines the FSM state encoding, the packed command record stored
//           in the command FIFO, and the default timeout read-data pattern.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package wb_cmd_initiator_pkg;

    // Command record width: we(1) + adr(32) + dat(32) + sel(4)
    localparam int CMD_W = 1 + 32 + 32 + 4;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/wb_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_cmd_fifo
// Purpose : Synchronous FIFO, DEPTH x WIDTH, registered full/empty flags and
//           no write-to-read bypass (a write is visible one cycle later).
// Ports   : clk, rst            clock, synchronous active-high reset
//           i_wr_en, i_wr_data  push request (ignored while full)
//           i_rd_en             pop request (ignored while empty)
//           o_rd_data           head entry
//           o_full, o_empty     registered status flags
// Rev     : 1.0  initial release
// ============================================================================
module wb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             r_full;
    logic             r_empty;

    logic             w_wr;
    logic             w_rd;
    logic [c_AW:0]    w_wr_ptr_nxt;
    logic [c_AW:0]    w_rd_ptr_nxt;

    assign w_wr = i_wr_en && !r_full;
    assign w_rd = i_rd_en && !r_empty;

    assign w_wr_ptr_nxt = r_wr_ptr + {{c_AW{1'b0}}, w_wr};
    assign w_rd_ptr_nxt = r_rd_ptr + {{c_AW{1'b0}}, w_rd};

    // Flags are computed from the next pointers so they can be registered;
    // the extra pointer MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full   <= (w_wr_ptr_nxt[c_AW] != w_rd_ptr_nxt[c_AW]) &&
                        (w_wr_ptr_nxt[c_AW-1:0] == w_rd_ptr_nxt[c_AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule
`default_nettype wire

// File: rtl/wb_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module  : wb_cmd_initiator
// Purpose : Wishbone classic-cycle bus master. Queued commands are issued as
//           single read/write cycles; each yields one response. Every cycle
//           is bounded by a timeout that returns ERR_DATA with rsp_err=1.
// Ports   : wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//           cmd_valid/ready/we/adr/dat/sel  command push interface
//           rsp_valid/ready/dat/err     response interface
//           wbm_*                       Wishbone master signals
//           busy                        work queued or in flight
//           to_count                    saturating timeout counter
// Rev     : 1.0  initial release
// ============================================================================
module wb_cmd_initiator
    import wb_cmd_initiator_pkg::*;
#(
    parameter int          CMD_DEPTH = 4,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy,
    output logic [15:0] to_count
);

    // Timer only has to reach TIMEOUT-1.
    localparam int             c_TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    cmd_t              r_cmd, w_cmd_nxt;
    logic              r_cyc, w_cyc_nxt;
    logic [c_TW-1:0]   r_timer, w_timer_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]       r_rsp_dat, w_rsp_dat_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;
    logic [15:0]       r_to_count, w_to_count_nxt;

    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CMD_W-1:0]  w_head;
    cmd_t              w_push_cmd;

    assign w_push_cmd = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};

    wb_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_wr_en   (cmd_valid),
        .i_wr_data (w_push_cmd),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_cyc       <= 1'b0;
            r_timer     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_to_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cyc       <= w_cyc_nxt;
            r_timer     <= w_timer_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_to_count  <= w_to_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_cyc_nxt       = r_cyc;
        w_timer_nxt     = r_timer;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;
        w_to_count_nxt  = r_to_count;
        w_pop           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_cmd_nxt   = cmd_t'(w_head);
                    w_cyc_nxt   = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_BUS;
                end
            end

            ST_BUS: begin
                // Ack is checked first so it wins over a same-cycle expiry.
                if (wbm_ack_i) begin
                    w_cyc_nxt       = 1'b0;
                    w_rsp_dat_nxt   = r_cmd.we ? 32'h0 : wbm_dat_i;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_RESP;
                end else if (r_timer == c_TO_LAST) begin
                    w_cyc_nxt       = 1'b0;
                    w_rsp_dat_nxt   = ERR_DATA;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    if (r_to_count != 16'hFFFF) begin
                        w_to_count_nxt = r_to_count + 16'd1;
                    end
                    w_state_nxt     = ST_RESP;
                end else begin
                    w_timer_nxt = r_timer + c_TW'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end

            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = !w_full;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_cmd.we;
    assign wbm_sel_o = r_cmd.sel;
    assign wbm_adr_o = r_cmd.adr;
    assign wbm_dat_o = r_cmd.dat;
    assign busy      = !w_empty || (r_state != ST_IDLE);
    assign to_count  = r_to_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_initiator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_wb_cmd_initiator
// Purpose : Self-checking bench for wb_cmd_initiator. A Wishbone responder
//           model picks an ack delay per cycle; the expected cycle length,
//           response and timeout count follow directly from that delay.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wb_cmd_initiator;
    import wb_cmd_initiator_pkg::*;

    localparam int          TO    = 8;
    localparam int          DEPTH = 4;
    localparam logic [31:0] ERR   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        busy;
    logic [15:0] to_count;

    always #5 clk = ~clk;

    wb_cmd_initiator #(
        .CMD_DEPTH (DEPTH),
        .TIMEOUT   (TO),
        .ERR_DATA  (ERR)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .busy      (busy),
        .to_count  (to_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    // Reference model state
    cmd_t        exp_cmd[$];     // pushed, not yet seen on the bus (push order)
    rsp_t        exp_rsp[$];     // responses owed to the consumer
    int          exp_to      = 0;
    int          rdy_mode    = 1;    // 0 hold low, 1 hold high, 2 random
    bit          stray_en    = 0;
    int          force_delay = -1;   // -1 = random ack delay
    bit          force_rd_en = 0;
    logic [31:0] force_rdata = '0;

    // Responder / monitor state
    int          cyc_len  = 0;
    bit          prev_cyc = 0;
    cmd_t        cur;
    int          cur_d    = 0;
    logic [31:0] cur_rd   = '0;

    // Responder + bus/response monitor. An ack delay d means ack is presented
    // in bus cycle d+1; if that is beyond TO cycles the command must time out.
    always @(negedge clk) begin
        if (rst) begin
            cyc_len   = 0;
            prev_cyc  = 0;
            exp_to    = 0;
            wbm_ack_i = 1'b0;
            wbm_dat_i = '0;
            rsp_ready = 1'b0;
        end else begin
            chk("stb_eq_cyc", 32'(wbm_stb_o), 32'(wbm_cyc_o));
            if (wbm_cyc_o) begin
                cyc_len++;
                if (cyc_len == 1) begin
                    chk("prev_rsp_consumed", 32'(exp_rsp.size()), 32'd0);
                    chk("new_cyc_rsp_valid", 32'(rsp_valid), 32'd0);
                    if (exp_cmd.size() == 0) begin
                        chk("unexpected_cycle", 32'd0, 32'd1);
                    end else begin
                        cur = exp_cmd.pop_front();
                    end
                    chk("bus_adr", wbm_adr_o, cur.adr);
                    chk("bus_dat", wbm_dat_o, cur.dat);
                    chk("bus_we",  32'(wbm_we_o), 32'(cur.we));
                    chk("bus_sel", 32'(wbm_sel_o), 32'(cur.sel));
                    cur_d  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, TO + 1));
                    cur_rd = force_rd_en ? force_rdata : $urandom;
                end else begin
                    chk("hold_adr", wbm_adr_o, cur.adr);
                    chk("hold_dat", wbm_dat_o, cur.dat);
                    chk("hold_we_sel", {27'b0, wbm_we_o, wbm_sel_o}, {27'b0, cur.we, cur.sel});
                end
                wbm_ack_i = (cyc_len == cur_d + 1);
                wbm_dat_i = wbm_ack_i ? cur_rd : $urandom;
            end else begin
                if (prev_cyc) begin
                    chk("cyc_len", 32'(cyc_len), 32'((cur_d < TO) ? cur_d + 1 : TO));
                    chk("rsp_valid_at_end", 32'(rsp_valid), 32'd1);
                    if (cur_d >= TO) begin
                        if (exp_to < 65535) exp_to++;
                        exp_rsp.push_back('{dat: ERR, err: 1'b1});
                    end else begin
                        exp_rsp.push_back('{dat: (cur.we ? 32'h0 : cur_rd), err: 1'b0});
                    end
                    chk("to_count", 32'(to_count), 32'(exp_to));
                    cyc_len = 0;
                end
                wbm_ack_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                wbm_dat_i = $urandom;
            end
            prev_cyc = wbm_cyc_o;

            rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
            if (rsp_valid) begin
                chk("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
                if (rsp_ready && exp_rsp.size() != 0) begin
                    chk("rsp_dat", rsp_dat, exp_rsp[0].dat);
                    chk("rsp_err", 32'(rsp_err), 32'(exp_rsp[0].err));
                    void'(exp_rsp.pop_front());
                end
            end
        end
    end

    task automatic push(input cmd_t c);
        bit ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_we    = c.we;
            cmd_adr   = c.adr;
            cmd_dat   = c.dat;
            cmd_sel   = c.sel;
            if (cmd_ready) begin
                ok = 1;
                exp_cmd.push_back(c);
            end
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_cmd.size() == 0 && exp_rsp.size() == 0 && !busy && !wbm_cyc_o) done = 1;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_cyc",       32'(wbm_cyc_o), 32'd0);
        chk("rst_stb",       32'(wbm_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_to_count",  32'(to_count),  32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_cmd.delete();
        exp_rsp.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cmd_t c;
        bit   seen;

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
        cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("init_cyc",       32'(wbm_cyc_o), 32'd0);
        chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("init_rsp_dat",   rsp_dat,        32'd0);
        chk("init_rsp_err",   32'(rsp_err),   32'd0);
        chk("init_adr",       wbm_adr_o,      32'd0);
        chk("init_busy",      32'(busy),      32'd0);
        chk("init_to_count",  32'(to_count),  32'd0);
        chk("init_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write to debug window, ack in third bus cycle
        force_delay = 2;
        push('{we: 1'b1, adr: 32'h30FF_FFF8, dat: 32'h1234_5678, sel: 4'hF});
        drain();

        // Read, immediate ack, fixed return data (minimum latency)
        force_delay = 0; force_rd_en = 1; force_rdata = 32'hA5A5_0001;
        push('{we: 1'b0, adr: 32'h30FF_FFFC, dat: 32'h0, sel: 4'hF});
        drain();
        force_rd_en = 0;

        // Timeout, then ack on the last permissible cycle
        force_delay = TO;
        push('{we: 1'b0, adr: 32'h3000_0010, dat: 32'h0, sel: 4'h3});
        drain();
        chk("to_after_timeout", 32'(to_count), 32'd1);
        force_delay = TO - 1;
        push('{we: 1'b0, adr: 32'h3000_0014, dat: 32'h0, sel: 4'hC});
        drain();
        chk("to_after_ack_wins", 32'(to_count), 32'd1);

        // Backpressure: one response parked, then fill the FIFO
        force_delay = -1;
        rdy_mode = 0;
        push('{we: 1'b1, adr: 32'h1000_0000, dat: 32'h0000_0001, sel: 4'h1});
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("parked_rsp_seen", 32'(seen), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            push('{we: k[0], adr: 32'h1000_0100 + 32'(k * 4), dat: 32'hC0DE_0000 + 32'(k), sel: 4'hF});
        end
        @(negedge clk);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("stalled_no_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("stalled_busy",   32'(busy),      32'd1);
        rdy_mode = 2;
        push('{we: 1'b0, adr: 32'h1000_0200, dat: 32'h0, sel: 4'hF});
        drain();

        // Reset while a bus cycle is in flight
        force_delay = TO + 1;
        rdy_mode = 1;
        push('{we: 1'b0, adr: 32'h2000_0000, dat: 32'h0, sel: 4'hF});
        push('{we: 1'b1, adr: 32'h2000_0004, dat: 32'h5555_AAAA, sel: 4'hF});
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = wbm_cyc_o;
        end
        chk("cyc_before_reset", 32'(seen), 32'd1);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_idle_cyc", 32'(wbm_cyc_o), 32'd0);
            chk("post_rst_no_rsp",   32'(rsp_valid), 32'd0);
        end

        // Stray acks while idle
        stray_en = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("stray_idle_cyc", 32'(wbm_cyc_o), 32'd0);
            chk("stray_idle_rsp", 32'(rsp_valid), 32'd0);
        end

        // Randomised traffic with stray acks and random response throttling
        force_delay = -1;
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            c.we  = 1'($urandom_range(0, 1));
            c.adr = ($urandom_range(0, 3) == 0) ? 32'h30FF_FFF8 : $urandom;
            c.dat = $urandom;
            c.sel = 4'($urandom_range(0, 15));
            push(c);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        stray_en = 0;
        chk("final_to_count", 32'(to_count), 32'(exp_to));
        chk("final_busy",     32'(busy),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
